// File: rtl/arb_pkg.sv
// Shared sizing, types and index helper for the round-robin arbiter slice.
package arb_pkg;

   localparam int NUM_REQ_MAX = 8;

   typedef logic [NUM_REQ_MAX-1:0] req_vec_t;

   // Single-step modulo: callers guarantee 0 <= a < 2*n.
   function automatic int wrap_idx(input int a, input int n);
      return (a >= n) ? a - n : a;
   endfunction

endpackage

// File: rtl/ps_fixed.sv
// Combinational fixed-priority selector: isolates the lowest set request bit.
module ps_fixed #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   // Two's-complement trick keeps only the least significant set bit.
   assign gnt = req & (~req + N'(1));

endmodule

// File: rtl/rr_arb4.sv
// Registered round-robin arbiter: rotate by last+1, fixed-priority pick, rotate back.
// Macro RR_ARB_GRANT_HOLD_EN: current grantee keeps gnt while its req stays high.
module rr_arb4
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       en,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       busy
);

   localparam int IW = $clog2(NUM_REQ);

   generate
      if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
         $error("rr_arb4: NUM_REQ out of range");
      end
   endgenerate

   logic [NUM_REQ-1:0] gnt_reg, gnt_next;
   logic [NUM_REQ-1:0] rot_req, rot_sel, gnt_rr;
   logic [IW-1:0]      last_reg, last_next;
   logic [IW-1:0]      idx_reg, idx_next;
   logic [IW-1:0]      start;
   logic [IW-1:0]      rr_idx;

   // Scan starts one past the most recent winner.
   assign start = (last_reg == IW'(NUM_REQ - 1)) ? '0 : last_reg + IW'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign rot_req[gi] = req[IW'(wrap_idx(gi + int'(start), NUM_REQ))];
         assign gnt_rr[gi]  = rot_sel[IW'(wrap_idx(gi + NUM_REQ - int'(start), NUM_REQ))];
      end
   endgenerate

   ps_fixed #(
      .N (NUM_REQ)
   ) u_ps_fixed (
      .req (rot_req),
      .gnt (rot_sel)
   );

   always_comb begin
      rr_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_rr[i]) rr_idx = IW'(i);
      end
   end

   always_comb begin
      gnt_next  = '0;
      idx_next  = '0;
      last_next = last_reg;
      if (en) begin
`ifdef RR_ARB_GRANT_HOLD_EN
         // last already equals the holder's index, so it stays put.
         if (|(gnt_reg & req)) begin
            gnt_next = gnt_reg;
            idx_next = idx_reg;
         end else
`endif
         if (|req) begin
            gnt_next  = gnt_rr;
            idx_next  = rr_idx;
            last_next = rr_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         gnt_reg  <= '0;
         idx_reg  <= '0;
         last_reg <= IW'(NUM_REQ - 1);
      end else begin
         gnt_reg  <= gnt_next;
         idx_reg  <= idx_next;
         last_reg <= last_next;
      end
   end

   assign gnt     = gnt_reg;
   assign gnt_idx = idx_reg;
   assign busy    = |gnt_reg;

endmodule

// File: tb/tb_rr_arb4.sv
// Scoreboard bench for rr_arb4 (NUM_REQ=4); honours RR_ARB_GRANT_HOLD_EN if defined.
module tb_rr_arb4;

   localparam int N = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       en    = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       busy;

   always #5 clock = ~clock;

   rr_arb4 #(
      .NUM_REQ (N)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .busy    (busy)
   );

   typedef struct {
      logic [3:0] gnt;
      int         tag;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   rand_phase = 1'b0;
   int   wait_cnt[4];

   // Reference model state: behavioural scan from last+1.
   logic [3:0] m_gnt  = 4'b0000;
   int         m_last = 3;

   task automatic model_step(input logic r_rst, input logic r_en, input logic [3:0] r_req);
      logic [3:0] g;
      logic       hold;
      g    = 4'b0000;
      hold = 1'b0;
`ifdef RR_ARB_GRANT_HOLD_EN
      hold = r_en && ((m_gnt & r_req) != 4'b0000);
`endif
      if (r_rst) begin
         m_gnt  = 4'b0000;
         m_last = 3;
      end else if (!r_en) begin
         m_gnt = 4'b0000;
      end else if (!hold) begin
         for (int k = 1; k <= 4; k++) begin
            int p;
            p = (m_last + k) % 4;
            if (r_req[p] && g == 4'b0000) begin
               g[p]   = 1'b1;
               m_last = p;
            end
         end
         m_gnt = g;
      end
   endtask

   // Drive one cycle of stimulus at the negedge and queue its expected grant.
   task automatic apply(input logic r_rst, input logic r_en, input logic [3:0] r_req,
                        input logic [3:0] exp_g, input bit use_model, input int tag);
      exp_t e;
      @(negedge clock);
      reset = r_rst;
      en    = r_en;
      req   = r_req;
      model_step(r_rst, r_en, r_req);
      e.gnt = use_model ? m_gnt : exp_g;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   function automatic logic [1:0] enc(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   // Monitor: one comparison per presented cycle, sampled just after the edge.
   always @(posedge clock) begin
      exp_t       e;
      logic [1:0] ei;
      #1;
      if (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         ei = enc(e.gnt);
         checks++;
         if (gnt !== e.gnt || gnt_idx !== ei || busy !== (|e.gnt)) begin
            errors++;
            $display("FAIL vec%0d: got gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                     e.tag, gnt, gnt_idx, busy, e.gnt, ei, |e.gnt);
         end else begin
            $display("vec%0d: req=%b en=%b rst=%b gnt=%b idx=%0d busy=%b ok",
                     e.tag, req, en, reset, gnt, gnt_idx, busy);
         end
         checks++;
         if (!$onehot0(gnt)) begin
            errors++;
            $display("FAIL onehot vec%0d: got gnt=%b, expected one-hot or zero", e.tag, gnt);
         end
`ifndef RR_ARB_GRANT_HOLD_EN
         if (rand_phase) begin
            for (int i = 0; i < 4; i++) begin
               if (req[i]) begin
                  wait_cnt[i] = gnt[i] ? 0 : wait_cnt[i] + 1;
                  checks++;
                  if (wait_cnt[i] >= N) begin
                     errors++;
                     $display("FAIL starve vec%0d: requester %0d waited %0d cycles, limit %0d",
                              e.tag, i, wait_cnt[i], N - 1);
                  end
               end else begin
                  wait_cnt[i] = 0;
               end
            end
         end
`endif
      end
   end

   initial begin
      logic [3:0] rq;
      logic [3:0] rnd;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

      apply(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0);
      apply(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 1);
`ifndef RR_ARB_GRANT_HOLD_EN
      apply(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 2);
      apply(1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, 3);
      apply(1'b0, 1'b1, 4'b1111, 4'b0100, 1'b0, 4);
      apply(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 5);
      apply(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 6);
      apply(1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, 7);
      apply(1'b0, 1'b1, 4'b1111, 4'b0100, 1'b0, 8);
      apply(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 9);
      apply(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 10);
      apply(1'b0, 1'b1, 4'b0101, 4'b0100, 1'b0, 11);
      apply(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 12);
      apply(1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, 13);
      apply(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 14);
      apply(1'b0, 1'b1, 4'b1111, 4'b0100, 1'b0, 15);
      apply(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 16);
      apply(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 17);
      apply(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 18);
      apply(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 19);
      apply(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 20);
      apply(1'b0, 1'b1, 4'b0110, 4'b0010, 1'b0, 21);
      apply(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 22);
      apply(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 23);
`else
      apply(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0, 2);
      apply(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0, 3);
      apply(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0, 4);
      apply(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 5);
      apply(1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 6);
      apply(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 7);
      apply(1'b0, 1'b1, 4'b0011, 4'b0010, 1'b0, 8);
      apply(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 9);
      apply(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 10);
      apply(1'b0, 1'b1, 4'b1100, 4'b0100, 1'b0, 11);
`endif

      // Sticky random requesters: a request stays up until it is granted.
      apply(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 99);
      rand_phase = 1'b1;
      rq = 4'b0000;
      for (int c = 0; c < 1000; c++) begin
         rnd = 4'($urandom_range(0, 15));
         rq  = (rq & ~m_gnt) | rnd;
         apply(1'b0, 1'b1, rq, 4'b0000, 1'b1, 1000 + c);
      end

      @(posedge clock);
      #3;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
